cbus_sram_responder: RTL and testbench
======================================

# cbus_sram_responder

CBus target that serves single and burst transactions from a word-organised on-chip memory. It sits at the downstream end of the CBus, behind the arbiter or directly behind a cache. It acts as the memory/device model for simulation and as a small scratchpad RAM on FPGA. First-beat latency is configurable, and an inject-stall input lets the bench exercise initiator wait handling.

## Interface
- WORDS, default 1024: memory depth in 32-bit words; must be a power of two, ≥ 16.
- LATENCY, default 2: cycles from acceptance to the earliest first beat; must be ≥ 1.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low; clock clk.
- req  in  cbus_req_t  request fields:
  - valid, is_write, size, addr (byte address), strobe[3:0], data[31:0].
  - len: beats minus one, 0..15.
- resp  out  cbus_resp_t  ready, last, data[31:0].
- stall  in  1  when high, suppresses ready in the current cycle (verification hook; tie 0 in synthesis).

## Operation
- Word index = addr[2 +: log2(WORDS)]. Upper address bits and addr[1:0] are ignored.
- The burst address is incrementing: the index advances by 1 per beat and wraps modulo WORDS.
- size is ignored. Reads always return the full 32-bit word. Writes are byte-masked by strobe.
- Memory contents are not affected by reset and are undefined until written.
- FSM states:
  - IDLE: resp = 0. If req.valid, latch the index, len and is_write, then go to WAIT (LATENCY > 1) or BEAT (LATENCY = 1). The latency counter loads LATENCY-1.
  - WAIT: decrement the counter. At 1, go to BEAT. stall has no effect here.
  - BEAT: if stall = 0, assert ready for one cycle.
    - Read: resp.data = mem[idx].
    - Write: at the clock edge, mem[idx] byte i ← req.data byte i for each strobe[i] = 1.
    - Increment idx and the beat counter.
    - On the beat where count = len, also assert last and go to DONE.
    - If stall = 1: ready = last = 0, data = 0, nothing advances.
  - DONE: resp = 0, req.valid ignored for this cycle (turnaround), go to IDLE.
- The initiator holds valid, is_write, addr and len stable for the whole transaction. It presents the current write beat's data/strobe in each cycle and advances them only after seeing ready.
- Latched fields are used after acceptance. Changes to req.addr/len mid-burst have no effect.
- resp is all-zero whenever ready = 0.
- Read data is taken from the current array contents. A write beat is visible to any later read beat, including a read issued right after DONE.

## Timing
- Reset: state IDLE, counters 0, resp.ready = 0, resp.last = 0, resp.data = 0, starting the cycle after the sampled resetn = 0.
- Reset mid-burst aborts immediately; no further ready. A write beat in the reset cycle is not performed.
- Acceptance occurs in a cycle T with state IDLE and req.valid = 1. With no stall, the first ready is in cycle T+LATENCY.
- Beats without stall are back-to-back, one per cycle. A burst of len+1 beats ends with last in cycle T+LATENCY+len.
- Each stall cycle in BEAT delays every remaining beat by one cycle.
- Minimum spacing: if last is in cycle L, DONE is in L+1 and the earliest next acceptance is in L+2. Back-to-back requests therefore have a gap of LATENCY+1 cycles between the last beat and the next first beat.
- Single-beat transaction (len = 0): ready and last are asserted in the same cycle.
- req.valid dropping before completion is a protocol violation. The behaviour is unspecified, but the block must return to IDLE within len+LATENCY+2 cycles.

## Test plan
1. LATENCY = 2. Write len = 0, addr 0x10, data 0xDEADBEEF, strobe 0xF, valid in cycle 5 -> ready = last = 1 in cycle 7. A later read of 0x10 returns 0xDEADBEEF with ready = last in acceptance+2.
2. 4-beat write (len = 3) at 0x100 with data 1, 2, 3, 4, then a 4-beat read at 0x100 -> 4 consecutive ready cycles, data 1, 2, 3, 4, last only on the 4th, resp = 0 in all other cycles.
3. Word 0x20 = 0x11223344, then a write of 0xAABBCCDD with strobe 0b0101 -> read returns 0x11BB33DD.
4. 8-beat read with stall high on beats 3 and 4 (two cycles) -> ready pattern 1, 1, 0, 0, 1, 1, 1, 1, 1, 1. last arrives 2 cycles later than unstalled, and the data sequence is unchanged.
5. WORDS = 1024. 4-beat write starting at byte 0xFF8 (index 1022) -> writes indices 1022, 1023, 0, 1, verified by single-beat reads.
6. Reset asserted after beat 2 of an 8-beat write -> no ready in the following cycles, and the next request is accepted normally. Words for beats 3..8 keep their prior values; beats 1..2 are written.

Source files
------------

// File: rtl/cbus_sram_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cbus_sram_responder                                                      |
// | CBus target serving single/burst accesses from a word-organised RAM.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  input  logic       stall
);

  localparam int                c_ADDR_W   = $clog2(WORDS);
  localparam int                c_LAT_W    = $clog2(LATENCY) + 1;
  localparam logic [c_LAT_W-1:0] c_LAT_INIT = c_LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_BEAT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_ADDR_W-1:0] r_idx;
  logic [3:0]          r_len;
  logic [3:0]          r_beat;
  logic                r_is_write;
  logic [c_LAT_W-1:0]  r_lat;
  logic [31:0]         r_mem [WORDS];

  logic w_fire;
  logic w_unused;

  assign w_fire   = (r_state == S_BEAT) && !stall;
  assign w_unused = ^{req.size, req.addr[31:c_ADDR_W+2], req.addr[1:0]};

  // Response is combinational so that stall can suppress a beat in its own cycle.
  always_comb begin
    resp = '0;
    if (w_fire) begin
      resp.ready = 1'b1;
      resp.last  = (r_beat == r_len);
      if (!r_is_write) begin
        resp.data = r_mem[r_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_is_write <= 1'b0;
      r_lat      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req.valid) begin
            r_idx      <= req.addr[2 +: c_ADDR_W];
            r_len      <= req.len;
            r_is_write <= req.is_write;
            r_beat     <= '0;
            r_lat      <= c_LAT_INIT;
            r_state    <= (LATENCY > 1) ? S_WAIT : S_BEAT;
          end
        end
        S_WAIT: begin
          r_lat <= r_lat - c_LAT_W'(1);
          if (r_lat == c_LAT_W'(1)) begin
            r_state <= S_BEAT;
          end
        end
        S_BEAT: begin
          if (!stall) begin
            r_idx  <= r_idx + c_ADDR_W'(1);
            r_beat <= r_beat + 4'd1;
            if (r_beat == r_len) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array is not reset; a beat landing in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (resetn && w_fire && r_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (req.strobe[i]) begin
          r_mem[r_idx][8*i +: 8] <= req.data[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cbus_sram_responder.sv
`default_nettype none
// Bench for cbus_sram_responder: directed plan steps plus randomized bursts
// checked cycle-by-cycle against a word-array reference model.
module tb_cbus_sram_responder;
  import cbus_pkg::*;

  localparam int WORDS   = 1024;
  localparam int LATENCY = 2;

  logic       clk;
  logic       resetn;
  logic       stall;
  cbus_req_t  req;
  cbus_resp_t resp;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [WORDS];
  logic [31:0] g_wd [16];
  logic [3:0]  g_ws [16];
  bit          g_after_last = 0;
  logic [31:0] rd;

  cbus_sram_responder #(.WORDS(WORDS), .LATENCY(LATENCY)) dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .resp   (resp),
    .stall  (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input cbus_resp_t got, input cbus_resp_t exp,
                     input bit data_care);
    checks++;
    assert (data_care ? (got === exp) : ({got.ready, got.last} === {exp.ready, exp.last}))
    else begin
      failures++;
      $error("FAIL %s: observed ready=%0b last=%0b data=%08h expected ready=%0b last=%0b data=%08h",
             tag, got.ready, got.last, got.data, exp.ready, exp.last, exp.data);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic fill_rand(input bit rand_strobe);
    for (int i = 0; i < 16; i++) begin
      g_wd[i] = $urandom;
      g_ws[i] = rand_strobe ? 4'($urandom) : 4'hF;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req       = cbus_req_t'({$urandom, $urandom, $urandom});
      req.valid = 1'b0;
      stall     = 1'($urandom_range(1));
      @(negedge clk);
      chk("idle", resp, '0, 1'b1);
    end
    g_after_last = 0;
  endtask

  // One transaction. early: presented during the DONE cycle of the previous one,
  // so acceptance happens one cycle later. rst_at>0 aborts with reset after that many beats.
  task automatic run_txn(input string tag, input bit we, input logic [31:0] addr, input int len,
                         input bit early, input int stall_pct, input logic [31:0] stall_mask,
                         input int rst_at, output logic [31:0] last_data);
    int unsigned base;
    int          beat, pc, c, acc;
    bit          stall_now, done;
    cbus_resp_t  exp;
    base = (addr >> 2) % WORDS;
    beat = 0; pc = 0; c = 0; done = 0;
    acc  = early ? 1 : 0;
    last_data = '0;
    while (!done) begin
      @(posedge clk); #1;
      if (rst_at > 0 && beat == rst_at) begin
        resetn    = 1'b0;
        req.valid = 1'b0;
        stall     = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk({tag, "_post_rst"}, resp, '0, 1'b1);
        g_after_last = 0;
        return;
      end
      req.valid    = 1'b1;
      req.is_write = we;
      req.addr     = addr;
      req.len      = 4'(len);
      req.size     = 3'($urandom);
      req.data     = we ? g_wd[beat] : $urandom;
      req.strobe   = we ? g_ws[beat] : 4'($urandom);
      if (c >= acc + LATENCY)
        stall_now = (pc < 32 && stall_mask[pc]) || ($urandom_range(99) < stall_pct);
      else
        stall_now = 1'($urandom_range(1));
      stall = stall_now;
      @(negedge clk);
      exp = '0;
      if (c >= acc + LATENCY && !stall_now) begin
        exp.ready = 1'b1;
        exp.last  = (beat == len);
        if (!we) exp.data = m_mem[(base + beat) % WORDS];
      end
      chk(tag, resp, exp, !(we && exp.ready));
      if (exp.ready) begin
        if (we) begin
          for (int i = 0; i < 4; i++)
            if (g_ws[beat][i]) m_mem[(base + beat) % WORDS][8*i +: 8] = g_wd[beat][8*i +: 8];
        end else begin
          last_data = resp.data;
        end
        if (exp.last) done = 1;
        beat++;
      end
      if (c >= acc + LATENCY) pc++;
      c++;
    end
    g_after_last = 1;
  endtask

  initial begin
    resetn = 1'b0;
    stall  = 1'b0;
    req    = '0;

    // Reset with valid asserted must not accept anything.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req.valid = 1'b1;
      @(negedge clk);
      chk("reset", resp, '0, 1'b1);
    end
    @(posedge clk); #1;
    resetn    = 1'b1;
    req.valid = 1'b0;
    @(negedge clk);
    chk("reset_release", resp, '0, 1'b1);

    // Fill the whole array so every later read has a known expectation.
    for (int b = 0; b < WORDS / 16; b++) begin
      fill_rand(0);
      run_txn("prefill", 1'b1, 32'(b * 64), 15, g_after_last, 10, 32'h0, 0, rd);
    end
    idle_cycles(1);

    // Single-beat write then read, ready and last together.
    fill_rand(0); g_wd[0] = 32'hDEADBEEF;
    run_txn("t1_wr", 1'b1, 32'h10, 0, 1'b0, 0, 32'h0, 0, rd);
    idle_cycles(2);
    run_txn("t1_rd", 1'b0, 32'h10, 0, 1'b0, 0, 32'h0, 0, rd);
    chk_word("t1_data", rd, 32'hDEADBEEF);
    idle_cycles(1);

    // Four-beat write/read, back-to-back via early presentation.
    fill_rand(0);
    for (int i = 0; i < 4; i++) g_wd[i] = 32'(i + 1);
    run_txn("t2_wr", 1'b1, 32'h100, 3, 1'b0, 0, 32'h0, 0, rd);
    run_txn("t2_rd", 1'b0, 32'h100, 3, 1'b1, 0, 32'h0, 0, rd);
    chk_word("t2_last_data", rd, 32'd4);
    idle_cycles(1);

    // Byte strobes.
    fill_rand(0); g_wd[0] = 32'h11223344;
    run_txn("t3_wr_full", 1'b1, 32'h20, 0, 1'b0, 0, 32'h0, 0, rd);
    idle_cycles(1);
    fill_rand(0); g_wd[0] = 32'hAABBCCDD; g_ws[0] = 4'b0101;
    run_txn("t3_wr_strb", 1'b1, 32'h20, 0, 1'b0, 0, 32'h0, 0, rd);
    idle_cycles(1);
    run_txn("t3_rd", 1'b0, 32'h20, 0, 1'b0, 0, 32'h0, 0, rd);
    chk_word("t3_data", rd, 32'h11BB33DD);
    idle_cycles(1);

    // Eight-beat read with two stall cycles where beats 3 and 4 would land.
    run_txn("t4_stall", 1'b0, 32'h300, 7, 1'b0, 0, 32'h0000_000C, 0, rd);
    idle_cycles(1);

    // Index wrap at the top of the array, then aliased reads.
    fill_rand(0);
    run_txn("t5_wr", 1'b1, 32'hFF8, 3, 1'b0, 0, 32'h0, 0, rd);
    idle_cycles(1);
    run_txn("t5_rd1022", 1'b0, 32'hFF8, 0, 1'b0, 0, 32'h0, 0, rd);
    run_txn("t5_rd1023", 1'b0, 32'hFFC, 0, 1'b1, 0, 32'h0, 0, rd);
    run_txn("t5_rd0",    1'b0, 32'h000, 0, 1'b1, 0, 32'h0, 0, rd);
    run_txn("t5_rd1_alias", 1'b0, 32'h1000_0005, 0, 1'b1, 0, 32'h0, 0, rd);
    chk_word("t5_wrap_data", rd, g_wd[3]);
    idle_cycles(1);

    // Reset after two beats of an eight-beat write.
    fill_rand(0);
    run_txn("t6_wr", 1'b1, 32'h200, 7, 1'b0, 0, 32'h0, 2, rd);
    idle_cycles(3);
    run_txn("t6_rd", 1'b0, 32'h200, 7, 1'b0, 0, 32'h0, 0, rd);

    // Randomized mix of reads and writes with stalls and strobes.
    for (int n = 0; n < 40; n++) begin
      bit          we, early;
      int          len;
      logic [31:0] a;
      we    = 1'($urandom_range(1));
      len   = $urandom_range(15);
      a     = $urandom;
      early = g_after_last && ($urandom_range(1) == 1);
      if (!early && g_after_last) idle_cycles($urandom_range(1, 3));
      fill_rand(1);
      run_txn(we ? "rnd_wr" : "rnd_rd", we, a, len, early, 20, 32'h0, 0, rd);
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
